// File: rtl/bch_error_locate_pkg.sv
// Shared definitions for the BCH error-locate stage: default code parameters
// and constant helper functions for the derived widths and counts.
package bch_error_locate_pkg;

    // Default parameter set: BCH(15,7) with T=2 over GF(2^4).
    localparam int BCH_M_DEF         = 4;
    localparam int BCH_T_DEF         = 2;
    localparam int BCH_DATA_BITS_DEF = 7;

    // Ceiling of log2(v); returns 0 for v <= 1.
    function automatic int bch_clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width needed for a root count or sigma degree in 0..T+1.
    function automatic int bch_cw(input int t);
        return bch_clog2(t + 2);
    endfunction

    // Number of Chien cycles needed to cover all data bits.
    function automatic int bch_cycles(input int data_bits, input int bits);
        return (data_bits + bits - 1) / bits;
    endfunction

    // Unused bit slots in the first cycle when data bits do not fill the lanes.
    function automatic int bch_pad(input int data_bits, input int bits);
        return bits * bch_cycles(data_bits, bits) - data_bits;
    endfunction

endpackage

// File: rtl/bch_chien_sum.sv
// XOR-reduces the T+1 Chien terms of one bit position and flags a zero sum,
// which marks that position as a root of sigma.
module bch_chien_sum #(
    parameter int M = 4,
    parameter int T = 2
) (
    input  logic [(T+1)*M-1:0] terms,
    output logic               zero
);

    logic [M-1:0] sum_s;

    // XOR all terms together and detect an all-zero result.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i <= T; i++) begin
            sum_s = sum_s ^ terms[i*M +: M];
        end
        zero = (sum_s == '0);
    end

endmodule

// File: rtl/bch_error_locate.sv
// BCH error-locate stage: turns Chien term vectors into an error bit vector,
// counts roots per codeword and flags the word as failed when the root count
// disagrees with the sigma degree captured at start.
module bch_error_locate
    import bch_error_locate_pkg::*;
#(
    parameter int M         = BCH_M_DEF,
    parameter int T         = BCH_T_DEF,
    parameter int DATA_BITS = BCH_DATA_BITS_DEF,
    parameter int BITS      = 1,
    localparam int CW       = bch_cw(T)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [CW-1:0]           sigma_deg,
    input  logic                    chien_valid,
    input  logic                    chien_first,
    input  logic                    chien_last,
    input  logic [(T+1)*M*BITS-1:0] chien,
    output logic                    err_valid,
    output logic                    err_first,
    output logic                    err_last,
    output logic [BITS-1:0]         err,
    output logic [CW-1:0]           err_count,
    output logic                    done,
    output logic                    failed
);

    localparam int SZ  = (T + 1) * M;
    localparam int PAD = bch_pad(DATA_BITS, BITS);
    // Sum width: count plus popcount cannot overflow before clamping.
    localparam int SW  = CW + 1 + bch_clog2(BITS + 1);
    localparam logic [SW-1:0] SAT = SW'(T + 1);

    logic [BITS-1:0] zero_s;
    logic [BITS-1:0] raw_s;
    logic [SW-1:0]   pop_s;
    logic [SW-1:0]   base_s;
    logic [SW-1:0]   sum_s;

    logic [BITS-1:0] err_d, err_q;
    logic            err_valid_d, err_valid_q;
    logic            err_first_d, err_first_q;
    logic            err_last_d, err_last_q;
    logic [CW-1:0]   count_d, count_q;
    logic [CW-1:0]   deg_pend_d, deg_pend_q;
    logic [CW-1:0]   deg_act_d, deg_act_q;
    logic            done_d, done_q;
    logic            failed_d, failed_q;

    for (genvar b = 0; b < BITS; b++) begin : g_sum
        bch_chien_sum #(.M(M), .T(T)) u_sum (
            .terms (chien[b*SZ +: SZ]),
            .zero  (zero_s[b])
        );
    end

    // Qualify zero sums with valid, drop pad slots of the first cycle, count roots.
    always_comb begin
        raw_s = '0;
        pop_s = '0;
        for (int i = 0; i < BITS; i++) begin
            raw_s[i] = (chien_first && (i < PAD)) ? 1'b0 : (zero_s[i] & chien_valid);
            pop_s    = pop_s + SW'(raw_s[i]);
        end
    end

    // Next-state for the error outputs, saturating count, degree pipeline and status.
    always_comb begin
        err_d       = raw_s;
        err_valid_d = chien_valid;
        err_first_d = chien_valid & chien_first;
        err_last_d  = chien_valid & chien_last;

        base_s = chien_first ? '0 : SW'(count_q);
        sum_s  = base_s + pop_s;
        if (chien_valid) begin
            count_d = (sum_s > SAT) ? CW'(T + 1) : sum_s[CW-1:0];
        end else begin
            count_d = count_q;
        end

        deg_pend_d = start ? sigma_deg : deg_pend_q;
        deg_act_d  = (chien_valid && chien_first) ? deg_pend_q : deg_act_q;

        done_d   = chien_valid & chien_last;
        failed_d = done_d ? (count_d != deg_act_d) : failed_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q       <= '0;
            err_valid_q <= 1'b0;
            err_first_q <= 1'b0;
            err_last_q  <= 1'b0;
            count_q     <= '0;
            deg_pend_q  <= '0;
            deg_act_q   <= '0;
            done_q      <= 1'b0;
            failed_q    <= 1'b0;
        end else begin
            err_q       <= err_d;
            err_valid_q <= err_valid_d;
            err_first_q <= err_first_d;
            err_last_q  <= err_last_d;
            count_q     <= count_d;
            deg_pend_q  <= deg_pend_d;
            deg_act_q   <= deg_act_d;
            done_q      <= done_d;
            failed_q    <= failed_d;
        end
    end

    assign err       = err_q;
    assign err_valid = err_valid_q;
    assign err_first = err_first_q;
    assign err_last  = err_last_q;
    assign err_count = count_q;
    assign done      = done_q;
    assign failed    = failed_q;

endmodule

// File: tb/tb_bch_error_locate.sv
// Bench for bch_error_locate on BCH(15,7), T=2, with BITS=1 and BITS=4 instances.
module tb_bch_error_locate;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance A: BITS=1 (7 cycles, no pad)
    logic        a_start, a_valid, a_first, a_last;
    logic [1:0]  a_deg;
    logic [11:0] a_chien;
    logic        a_err_valid, a_err_first, a_err_last, a_done, a_failed;
    logic [0:0]  a_err;
    logic [1:0]  a_err_count;

    // Instance B: BITS=4 (2 cycles, pad 1)
    logic        b_start, b_valid, b_first, b_last;
    logic [1:0]  b_deg;
    logic [47:0] b_chien;
    logic        b_err_valid, b_err_first, b_err_last, b_done, b_failed;
    logic [3:0]  b_err;
    logic [1:0]  b_err_count;

    bch_error_locate #(.M(4), .T(2), .DATA_BITS(7), .BITS(1)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .sigma_deg(a_deg),
        .chien_valid(a_valid), .chien_first(a_first), .chien_last(a_last), .chien(a_chien),
        .err_valid(a_err_valid), .err_first(a_err_first), .err_last(a_err_last),
        .err(a_err), .err_count(a_err_count), .done(a_done), .failed(a_failed)
    );

    bch_error_locate #(.M(4), .T(2), .DATA_BITS(7), .BITS(4)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .sigma_deg(b_deg),
        .chien_valid(b_valid), .chien_first(b_first), .chien_last(b_last), .chien(b_chien),
        .err_valid(b_err_valid), .err_first(b_err_first), .err_last(b_err_last),
        .err(b_err), .err_count(b_err_count), .done(b_done), .failed(b_failed)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Observation state for the currently selected instance.
    bit         sel;
    logic [3:0] q_err[$];
    logic [1:0] q_fl[$];
    int         idle_err;
    int         n_done;
    logic [1:0] done_cnt;
    logic       done_failed, done_last;
    logic [1:0] last_cnt;
    logic       last_failed;

    // Three M-bit terms whose XOR is zero when z=1, a random nonzero value otherwise.
    function automatic logic [11:0] make_terms(input bit z);
        logic [3:0] t0, t1, d;
        t0 = 4'($urandom);
        t1 = 4'($urandom);
        d  = z ? 4'd0 : 4'($urandom_range(1, 15));
        return {t0 ^ t1 ^ d, t1, t0};
    endfunction

    // Reference: error lanes of cycle c given the zero-sum pattern, with pad masking.
    function automatic logic [3:0] exp_err(input bit s, input logic [27:0] zp, input int c);
        logic [3:0] m;
        m = s ? ((c == 0) ? 4'b1110 : 4'b1111) : 4'b0001;
        return zp[c*4 +: 4] & m;
    endfunction

    // Reference: saturated root count of a whole word.
    function automatic int exp_count(input bit s, input logic [27:0] zp);
        int n;
        logic [3:0] e;
        n = 0;
        for (int c = 0; c < (s ? 2 : 7); c++) begin
            e = exp_err(s, zp, c);
            for (int b = 0; b < 4; b++) n += int'(e[b]);
        end
        return (n > 3) ? 3 : n;
    endfunction

    task automatic set_in(input bit st, input logic [1:0] dg, input bit v, input bit f,
                          input bit l, input logic [47:0] ch);
        if (sel) begin
            b_start = st; b_deg = dg; b_valid = v; b_first = f; b_last = l; b_chien = ch;
        end else begin
            a_start = st; a_deg = dg; a_valid = v; a_first = f; a_last = l; a_chien = ch[11:0];
        end
    endtask

    task automatic step();
        logic [3:0] e;
        logic [1:0] ec;
        logic v, f, l, dn, fl;
        @(posedge clk);
        #1;
        if (sel) begin
            {v, f, l, e, ec, dn, fl} = {b_err_valid, b_err_first, b_err_last, b_err, b_err_count, b_done, b_failed};
        end else begin
            {v, f, l, ec, dn, fl} = {a_err_valid, a_err_first, a_err_last, a_err_count, a_done, a_failed};
            e = {3'b000, a_err};
        end
        if (v) begin
            q_err.push_back(e);
            q_fl.push_back({f, l});
        end else if (e != 4'd0) begin
            idle_err++;
        end
        if (dn) begin
            n_done++; done_cnt = ec; done_failed = fl; done_last = l;
        end
        last_cnt = ec; last_failed = fl;
    endtask

    task automatic do_start(input logic [1:0] dg);
        set_in(1'b1, dg, 1'b0, 1'b0, 1'b0, 48'd0);
        step();
        set_in(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 48'd0);
    endtask

    task automatic drive_word(input logic [27:0] zp, input bit gaps, input bit start_last,
                              input logic [1:0] deg_next, input bit rst_mid);
        int ncyc, nb;
        logic [47:0] ch;
        ncyc = sel ? 2 : 7;
        nb   = sel ? 4 : 1;
        q_err.delete(); q_fl.delete(); idle_err = 0; n_done = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                set_in(1'b0, 2'd0, 1'b0, 1'($urandom), 1'($urandom), 48'({$urandom(), $urandom()}));
                step();
            end
            if (rst_mid && c == ncyc - 1) begin
                reset = 1'b1;
                set_in(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 48'd0);
                step(); step();
                reset = 1'b0;
                break;
            end
            ch = '0;
            for (int b = 0; b < nb; b++) ch[b*12 +: 12] = make_terms(zp[c*4 + b]);
            set_in(start_last && (c == ncyc - 1), deg_next, 1'b1, c == 0, c == ncyc - 1, ch);
            step();
        end
        set_in(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 48'd0);
        step(); step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            a_start = 1'($urandom); a_deg = 2'($urandom); a_valid = 1'b1; a_first = 1'($urandom);
            a_last = 1'($urandom); a_chien = 12'd0;
            b_start = 1'($urandom); b_deg = 2'($urandom); b_valid = 1'b1; b_first = 1'($urandom);
            b_last = 1'($urandom); b_chien = 48'd0;
            @(posedge clk); #1;
            n_cmp++;
            if ({a_err_valid, a_err_first, a_err_last, a_err, a_err_count, a_done, a_failed} !== 8'd0) begin
                n_bad++; $display("FAIL reset_a cyc%0d got %b want 0", k,
                    {a_err_valid, a_err_first, a_err_last, a_err, a_err_count, a_done, a_failed});
            end
            n_cmp++;
            if ({b_err_valid, b_err_first, b_err_last, b_err, b_err_count, b_done, b_failed} !== 11'd0) begin
                n_bad++; $display("FAIL reset_b cyc%0d got %b want 0", k,
                    {b_err_valid, b_err_first, b_err_last, b_err, b_err_count, b_done, b_failed});
            end
        end
        reset = 1'b0;
        a_start = 1'b0; a_valid = 1'b0; a_first = 1'b0; a_last = 1'b0;
        b_start = 1'b0; b_valid = 1'b0; b_first = 1'b0; b_last = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({a_err_valid, a_err, a_err_count, a_done, a_failed, b_err_valid, b_err, b_err_count, b_done, b_failed} !== 15'd0) begin
                n_bad++; $display("FAIL post_reset cyc%0d got a=%b b=%b want 0", k,
                    {a_err_valid, a_err, a_err_count, a_done, a_failed}, {b_err_valid, b_err, b_err_count, b_done, b_failed});
            end
        end
    endtask

    task automatic test_no_errors();
        sel = 1'b0;
        do_start(2'd0);
        drive_word(28'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        n_cmp++; if (q_err.size() != 7) begin n_bad++; $display("FAIL noerr_len got %0d want 7", q_err.size()); end
        foreach (q_err[i]) begin
            n_cmp++; if (q_err[i] !== 4'd0) begin n_bad++; $display("FAIL noerr_err[%0d] got %b want 0", i, q_err[i]); end
        end
        n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL noerr_done got %0d want 1", n_done); end
        n_cmp++; if (done_cnt !== 2'd0 || done_failed !== 1'b0) begin
            n_bad++; $display("FAIL noerr_status got cnt=%0d failed=%b want 0/0", done_cnt, done_failed); end
    endtask

    task automatic test_two_errors();
        logic [27:0] zp;
        sel = 1'b0;
        zp = '0; zp[2*4] = 1'b1; zp[5*4] = 1'b1;
        do_start(2'd2);
        drive_word(zp, 1'b0, 1'b0, 2'd0, 1'b0);
        n_cmp++; if (q_err.size() != 7) begin n_bad++; $display("FAIL two_len got %0d want 7", q_err.size()); end
        foreach (q_err[i]) begin
            n_cmp++;
            if (q_err[i] !== ((i == 2 || i == 5) ? 4'd1 : 4'd0)) begin
                n_bad++; $display("FAIL two_err[%0d] got %b want %0d", i, q_err[i], (i == 2 || i == 5)); end
        end
        n_cmp++; if (q_fl.size() == 7 && (q_fl[0] !== 2'b10 || q_fl[6] !== 2'b01)) begin
            n_bad++; $display("FAIL two_firstlast got %b/%b want 10/01", q_fl[0], q_fl[6]); end
        n_cmp++; if (n_done != 1 || done_last !== 1'b1) begin
            n_bad++; $display("FAIL two_done got n=%0d last=%b want 1/1", n_done, done_last); end
        n_cmp++; if (done_cnt !== 2'd2 || done_failed !== 1'b0) begin
            n_bad++; $display("FAIL two_status got cnt=%0d failed=%b want 2/0", done_cnt, done_failed); end
    endtask

    task automatic test_no_roots();
        sel = 1'b0;
        do_start(2'd2);
        drive_word(28'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        n_cmp++; if (done_cnt !== 2'd0 || done_failed !== 1'b1) begin
            n_bad++; $display("FAIL noroot_status got cnt=%0d failed=%b want 0/1", done_cnt, done_failed); end
        n_cmp++; if (last_failed !== 1'b1) begin
            n_bad++; $display("FAIL noroot_hold got failed=%b want 1", last_failed); end
        do_start(2'd2);
        drive_word(28'h1111111, 1'b0, 1'b0, 2'd0, 1'b0);
        foreach (q_err[i]) begin
            n_cmp++; if (q_err[i] !== 4'd1) begin n_bad++; $display("FAIL sat_err[%0d] got %b want 1", i, q_err[i]); end
        end
        n_cmp++; if (done_cnt !== 2'd3 || done_failed !== 1'b1) begin
            n_bad++; $display("FAIL sat_status got cnt=%0d failed=%b want 3/1", done_cnt, done_failed); end
    endtask

    task automatic test_pad();
        sel = 1'b1;
        do_start(2'd1);
        drive_word(28'h0000001, 1'b0, 1'b0, 2'd0, 1'b0);
        n_cmp++; if (q_err.size() != 2 || q_err[0] !== 4'd0) begin
            n_bad++; $display("FAIL pad_first got %b want 0000", q_err[0]); end
        n_cmp++; if (done_cnt !== 2'd0 || done_failed !== 1'b1) begin
            n_bad++; $display("FAIL pad_status got cnt=%0d failed=%b want 0/1", done_cnt, done_failed); end
        do_start(2'd1);
        drive_word(28'h0000010, 1'b0, 1'b0, 2'd0, 1'b0);
        n_cmp++; if (q_err.size() != 2 || q_err[1] !== 4'b0001) begin
            n_bad++; $display("FAIL pad_last got %b want 0001", q_err[1]); end
        n_cmp++; if (done_cnt !== 2'd1 || done_failed !== 1'b0) begin
            n_bad++; $display("FAIL pad_last_status got cnt=%0d failed=%b want 1/0", done_cnt, done_failed); end
    endtask

    task automatic test_back_to_back();
        logic [27:0] zp;
        sel = 1'b0;
        zp = '0; zp[1*4] = 1'b1; zp[6*4] = 1'b1;
        do_start(2'd2);
        drive_word(zp, 1'b0, 1'b1, 2'd1, 1'b0);
        n_cmp++; if (n_done != 1 || done_cnt !== 2'd2 || done_failed !== 1'b0) begin
            n_bad++; $display("FAIL b2b_w1 got n=%0d cnt=%0d failed=%b want 1/2/0", n_done, done_cnt, done_failed); end
        zp = '0; zp[3*4] = 1'b1;
        drive_word(zp, 1'b0, 1'b0, 2'd0, 1'b0);
        n_cmp++; if (n_done != 1 || done_cnt !== 2'd1 || done_failed !== 1'b0) begin
            n_bad++; $display("FAIL b2b_w2 got n=%0d cnt=%0d failed=%b want 1/1/0", n_done, done_cnt, done_failed); end
        do_start(2'd1);
        drive_word(zp, 1'b0, 1'b0, 2'd0, 1'b1);
        n_cmp++; if (n_done != 0) begin n_bad++; $display("FAIL b2b_rst_done got %0d want 0", n_done); end
        n_cmp++; if (last_cnt !== 2'd0 || last_failed !== 1'b0) begin
            n_bad++; $display("FAIL b2b_rst_state got cnt=%0d failed=%b want 0/0", last_cnt, last_failed); end
    endtask

    task automatic test_random();
        logic [27:0] zp;
        logic [1:0]  dg;
        int ncyc, ec;
        for (int w = 0; w < 40; w++) begin
            sel  = 1'($urandom);
            ncyc = sel ? 2 : 7;
            zp   = 28'($urandom) & 28'($urandom);
            dg   = 2'($urandom);
            do_start(dg);
            drive_word(zp, 1'b1, 1'b0, 2'd0, 1'b0);
            ec = exp_count(sel, zp);
            n_cmp++; if (q_err.size() != ncyc) begin
                n_bad++; $display("FAIL rnd%0d_len got %0d want %0d", w, q_err.size(), ncyc); end
            for (int c = 0; c < ncyc && c < q_err.size(); c++) begin
                n_cmp++; if (q_err[c] !== exp_err(sel, zp, c)) begin
                    n_bad++; $display("FAIL rnd%0d_err[%0d] got %b want %b", w, c, q_err[c], exp_err(sel, zp, c)); end
            end
            n_cmp++; if (idle_err != 0) begin n_bad++; $display("FAIL rnd%0d_idle_err got %0d want 0", w, idle_err); end
            n_cmp++; if (n_done != 1 || done_last !== 1'b1) begin
                n_bad++; $display("FAIL rnd%0d_done got n=%0d last=%b want 1/1", w, n_done, done_last); end
            n_cmp++; if (int'(done_cnt) != ec) begin
                n_bad++; $display("FAIL rnd%0d_count got %0d want %0d", w, done_cnt, ec); end
            n_cmp++; if (done_failed !== (ec != int'(dg))) begin
                n_bad++; $display("FAIL rnd%0d_failed got %b want %b", w, done_failed, (ec != int'(dg))); end
        end
    endtask

    initial begin
        reset = 1'b1;
        a_start = 1'b0; a_deg = 2'd0; a_valid = 1'b0; a_first = 1'b0; a_last = 1'b0; a_chien = 12'd0;
        b_start = 1'b0; b_deg = 2'd0; b_valid = 1'b0; b_first = 1'b0; b_last = 1'b0; b_chien = 48'd0;
        test_reset();
        test_no_errors();
        test_two_errors();
        test_no_roots();
        test_pad();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bch_error_locate.md
Name: bch_error_locate

Overview:
- Stage directly downstream of the Chien search. Consumes the per-bit Chien term vectors and XOR-reduces the T+1 terms for each bit. A zero sum marks a root of sigma, so that bit position is flagged as an error.
- Counts roots over each codeword and compares the count against the sigma degree captured at start. Flags the codeword as uncorrectable on mismatch.
- Feeds the data-correction XOR stage (err vector) and the decoder status logic (done/failed).

Parameters:
- P, `BCH_SANE, packed BCH parameter set; M = `BCH_M(P), T = `BCH_T(P).
- BITS, 1, bits per cycle; must match the upstream Chien instance.
- Derived localparams: CW = ceil(log2(T+2)) (count/degree width); CYCLES = ceil(`BCH_DATA_BITS(P)/BITS); PAD = BITS*CYCLES - `BCH_DATA_BITS(P).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  same pulse that starts the Chien search; qualifies sigma_deg.
- sigma_deg  in  CW  degree of sigma for the codeword being started.
- chien_valid  in  1  chien vector valid.
- chien_first  in  1  first valid cycle of a codeword.
- chien_last  in  1  last valid cycle of a codeword.
- chien  in  `BCH_SIGMA_SZ(P)*BITS  term vectors; term i of bit b at [(b*(T+1)+i)*M +: M].
- err_valid  out  1  err is valid.
- err_first  out  1  delayed chien_first.
- err_last  out  1  delayed chien_last.
- err  out  BITS  1 = bit position in error.
- err_count  out  CW  running root count, saturating.
- done  out  1  one-cycle pulse; err_count and failed are final.
- failed  out  1  held from done until the next done or reset.

Behaviour:
- Reset: every output and internal register clears to 0.
- Per-bit sum: S_b = XOR over i=0..T of the M-bit term i of bit b. Raw error r_b = (S_b == 0) & chien_valid.
- Pad masking: in a chien_first cycle, bits b < PAD are forced to r_b = 0. No masking when PAD = 0.
- Latency: 1 cycle. err, err_valid, err_first and err_last are registers loaded from the chien_* inputs of the previous cycle.
- Degree capture, two stages:
  - On start, deg_pend <= sigma_deg.
  - On chien_first & chien_valid, deg_act <= deg_pend.
  - Start coinciding with chien_last of the previous word is legal; the previous word still compares against the old deg_act.
- Count:
  - On chien_first & chien_valid, count <= popcount(r).
  - Otherwise, on chien_valid, count <= count + popcount(r).
  - Count saturates at T+1 and never wraps.
  - err_count mirrors the count register and updates in the same cycle as err.
- Completion: the cycle after chien_last & chien_valid, done = 1 and failed <= (next count != deg_act). This cycle coincides with err_last.
- CYCLES = 1: first and last are asserted together. The count loads popcount and done fires on the same edge.
- chien_valid low: err = 0; count holds.
- chien_first/chien_last without chien_valid are ignored.
- Reset mid-codeword: the codeword is abandoned, no done is issued, and deg_pend/deg_act clear.
- Arithmetic: the popcount of BITS bits is widened to CW+1 before the add, then clamped to T+1.

Decomposition:
- Shared defs (bch_defs.vh / bch.vh):
  - macro for CW from P;
  - function computing PAD from P and BITS;
  - a popcount/log2 helper function if not already present.
- One natural sub-module, bch_chien_sum: combinational XOR-reduce of the T+1 terms of one bit plus zero detect, instantiated BITS times in a generate loop.
- Pad masking, counting, degree capture and the done/failed registers stay in the top module.

Test Plan:
- Reset: assert reset 2 cycles with chien inputs toggling -> all outputs 0. Release reset -> outputs stay 0 until valid input arrives.
- BCH(15,7), T=2, BITS=1, sigma=1, deg 0 -> 7 err_valid cycles with err=0; done with err_count=0, failed=0.
- Same code, errors at data bits 2 and 5, deg 2 -> err=1 exactly on valid cycles 2 and 5 (1 cycle after input); done with err_count=2, failed=0.
- deg 2 but a sigma with no roots in the field -> err never set; done with err_count=0, failed=1. Then drive all-zero chien terms -> err_count saturates at 3, failed=1.
- BITS=4 (CYCLES=2, PAD=1), zero sum forced on bit 0 of the first cycle -> err[0]=0 in that cycle. The same zero on bit 0 of the last cycle -> err[0]=1.
- Back-to-back words: start with deg 1 on the chien_last cycle of a word whose deg is 2 and that has 2 roots -> first done failed=0. Second word with 1 root -> done failed=0. Reset during the second word -> no done.
